// File: rtl/vga_pixel_fetch.sv
// Scaled 3-bit RGB framebuffer feeding the VGA timing controller with same-cycle pixel colours.
// A one-pixel look-ahead read address hides the block RAM's synchronous read latency.

package vga_pkg;

  typedef struct packed {
    int unsigned h_visible;
    int unsigned h_front;
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned v_visible;
    int unsigned v_front;
    int unsigned v_sync;
    int unsigned v_back;
    int unsigned pixel_x_bits;
    int unsigned pixel_y_bits;
  } vga_params_t;

  localparam vga_params_t Vga640x480 = '{
    h_visible:    640,
    h_front:      16,
    h_sync:       96,
    h_back:       48,
    v_visible:    480,
    v_front:      10,
    v_sync:       2,
    v_back:       33,
    pixel_x_bits: 10,
    pixel_y_bits: 10
  };

endpackage

module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter vga_params_t params      = Vga640x480,
  parameter int unsigned FB_W        = 160,
  parameter int unsigned FB_H        = 120,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned FB_X_BITS   = 8,
  parameter int unsigned FB_Y_BITS   = 7
) (
  input  logic                           VGA_clk,
  input  logic                           reset_n,
  input  logic [params.pixel_x_bits-1:0] pixel_x_target_next,
  input  logic [params.pixel_y_bits-1:0] pixel_y_target_next,
  output logic                           pixel_value_next_R,
  output logic                           pixel_value_next_G,
  output logic                           pixel_value_next_B,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [FB_X_BITS-1:0]           wr_x,
  input  logic [FB_Y_BITS-1:0]           wr_y,
  input  logic [2:0]                     wr_rgb,
  output logic                           wr_drop,
  input  logic                           clr_req,
  input  logic [2:0]                     clr_rgb,
  output logic                           busy,
  output logic                           clr_done
);

  localparam int unsigned XBits = params.pixel_x_bits;
  localparam int unsigned YBits = params.pixel_y_bits;
  localparam int unsigned Cells = FB_W * FB_H;
  localparam int unsigned AddrW = $clog2(Cells);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] clr_addr_q, clr_addr_d;
  logic [2:0]       clr_rgb_q, clr_rgb_d;
  logic [2:0]       hold_q, hold_d;
  logic             wr_drop_q, wr_drop_d;
  logic [2:0]       rd_data_q;
  logic [2:0]       mem_q [Cells];

  logic             clr_last;
  logic             wr_fire;
  logic             wr_in_range;
  logic [AddrW-1:0] wr_addr;
  logic             ram_we;
  logic [AddrW-1:0] ram_waddr;
  logic [2:0]       ram_wdata;

  logic             x_is_zero;
  logic [XBits:0]   x_inc;
  logic [YBits:0]   y_inc;
  logic [YBits:0]   y_sel;
  logic [XBits:0]   col_raw;
  logic [YBits:0]   row_raw;
  logic [AddrW-1:0] rd_col;
  logic [AddrW-1:0] rd_row;
  logic [AddrW-1:0] rd_addr;
  logic [2:0]       pix;

  assign busy     = (state_q == StClear);
  assign wr_ready = (state_q == StIdle);
  assign clr_last = (clr_addr_q == AddrW'(Cells - 1));
  assign clr_done = busy && clr_last;
  assign wr_drop  = wr_drop_q;

  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);
  // Range is checked on the raw coordinates, so the linear address only matters when it fits.
  assign wr_addr     = AddrW'(wr_y) * AddrW'(FB_W) + AddrW'(wr_x);

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_rgb_d  = clr_rgb_q;
    unique case (state_q)
      StClear: begin
        if (clr_last) begin
          state_d = StIdle;
        end else begin
          clr_addr_d = clr_addr_q + AddrW'(1);
        end
      end
      StIdle: begin
        if (clr_req) begin
          state_d    = StClear;
          clr_addr_d = '0;
          clr_rgb_d  = clr_rgb;
        end
      end
    endcase
  end

  // The clear engine owns the write port; host writes only land while idle.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_addr_q;
    ram_wdata = clr_rgb_q;
    if (state_q == StClear) begin
      ram_we = 1'b1;
    end else if (wr_fire && wr_in_range) begin
      ram_we    = 1'b1;
      ram_waddr = wr_addr;
      ram_wdata = wr_rgb;
    end
  end

  assign wr_drop_d = wr_fire && !wr_in_range;

  // Address for the pixel one step ahead; at x==0 that is cell 0 of the next line.
  assign x_is_zero = (pixel_x_target_next == '0);
  assign x_inc     = {1'b0, pixel_x_target_next} + (XBits + 1)'(1);
  assign y_inc     = {1'b0, pixel_y_target_next} + (YBits + 1)'(1);
  assign y_sel     = x_is_zero ? y_inc : {1'b0, pixel_y_target_next};
  assign col_raw   = x_inc >> SCALE_SHIFT;
  assign row_raw   = y_sel >> SCALE_SHIFT;
  assign rd_col    = (32'(col_raw) > FB_W - 1) ? AddrW'(FB_W - 1) : AddrW'(col_raw);
  assign rd_row    = (32'(row_raw) > FB_H - 1) ? AddrW'(FB_H - 1) : AddrW'(row_raw);
  assign rd_addr   = rd_row * AddrW'(FB_W) + rd_col;

  // x==0 slot fetched the next line's row, so cell 0 for x==1 comes from the hold register.
  assign hold_d = x_is_zero ? rd_data_q : hold_q;

  always_comb begin
    pix = 3'b000;
    if (!busy) begin
      pix = (pixel_x_target_next == XBits'(1)) ? hold_q : rd_data_q;
    end
  end

  assign pixel_value_next_R = pix[2];
  assign pixel_value_next_G = pix[1];
  assign pixel_value_next_B = pix[0];

  always_ff @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
      clr_rgb_q  <= '0;
      hold_q     <= '0;
      wr_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      clr_rgb_q  <= clr_rgb_d;
      hold_q     <= hold_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  // Block RAM: read-before-write, so a same-address collision returns the old cell.
  always_ff @(posedge VGA_clk) begin
    if (ram_we) begin
      mem_q[ram_waddr] <= ram_wdata;
    end
    rd_data_q <= mem_q[rd_addr];
  end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- 3-bit RGB framebuffer stored at 1/2^SCALE_SHIFT of display resolution in block RAM (1R1W, synchronous read).
- Sits directly upstream of the VGA timing controller and runs on VGA_clk.
- Each cycle it consumes the controller's pixel_x_target_next/pixel_y_target_next and returns same-cycle pixel_value_next_R/G/B, despite the RAM's 1-cycle read latency, by look-ahead addressing.
- A valid/ready write port and a whole-buffer clear engine let the MCU-side logic update the image.

Parameters:
- params, vga_pkg::vga_params_t (640x480 mode), display timing; uses h_visible, v_visible, pixel_x_bits, pixel_y_bits.
- FB_W, 160, framebuffer width in cells.
- FB_H, 120, framebuffer height in cells.
- SCALE_SHIFT, 2, log2 of cell size in display pixels. Must be >=1. FB_W<<SCALE_SHIFT == h_visible and FB_H<<SCALE_SHIFT == v_visible.
- FB_X_BITS, 8, width of wr_x; must satisfy >= $clog2(FB_W).
- FB_Y_BITS, 7, width of wr_y; must satisfy >= $clog2(FB_H).

Ports:
- VGA_clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- pixel_x_target_next  in  params.pixel_x_bits  current pixel x from controller (0 outside visible).
- pixel_y_target_next  in  params.pixel_y_bits  current pixel y from controller (0 outside visible).
- pixel_value_next_R/_G/_B  out  1 each  colour for the current coordinate, same cycle.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accept.
- wr_x  in  FB_X_BITS  cell column.
- wr_y  in  FB_Y_BITS  cell row.
- wr_rgb  in  3  {R,G,B}.
- wr_drop  out  1  1-cycle pulse: accepted write was out of range and discarded.
- clr_req  in  1  start clear (level sampled in IDLE).
- clr_rgb  in  3  clear colour, captured when the clear starts.
- busy  out  1  clear in progress.
- clr_done  out  1  1-cycle pulse on the last clear write.

Behaviour:
- Clock and reset: one clock, VGA_clk. reset_n is asynchronous, active-low.
- FSM states: CLEAR, IDLE.
  - Reset enters CLEAR with colour 000 and clear address 0.
  - CLEAR writes one cell per cycle at addresses 0..FB_W*FB_H-1. On the last address, pulse clr_done and go to IDLE next cycle.
  - IDLE with clr_req=1: capture clr_rgb, address=0, enter CLEAR next cycle.
  - clr_req is ignored while in CLEAR.
  - Reset mid-clear restarts the clear from address 0 with colour 000.
- Reset values: pixel outputs 0, wr_ready 0, busy 1, clr_done 0, wr_drop 0, hold register 0.
- Write port:
  - wr_ready = (state==IDLE).
  - A transfer occurs when wr_valid && wr_ready. Address = wr_y*FB_W + wr_x, computed at full width with no truncation.
  - If wr_x>=FB_W or wr_y>=FB_H: no RAM write, and wr_drop pulses the cycle after the transfer.
  - A transfer in the same cycle as clr_req is performed first; the clear that follows overwrites it.
- Read address issued in cycle with coordinates (x,y):
  - col = min((x+1)>>SCALE_SHIFT, FB_W-1).
  - row = (x==0) ? min((y+1)>>SCALE_SHIFT, FB_H-1) : y>>SCALE_SHIFT.
- Hold register: loads RAM read data on every cycle with x==0.
- Output:
  - {R,G,B} = 000 when busy.
  - Otherwise hold register when x==1, else RAM read data.
- Why this works:
  - The last blanking cycle (x==0, old y) prefetches cell 0 of the next line's row.
  - Cell 0 is held for x=1, because the x==0 issue slot uses the next-line row.
  - Visible-region gating is done downstream, so output values outside the visible window are don't-care.
- Collision: a read and a write to the same address in the same cycle return the old data; the new data is visible from the next read.
- Latency: a write accepted in cycle t is visible to reads issued at t+1 or later.

Test Plan:
- Release reset, hold wr_valid=1 -> busy=1 and wr_ready=0 for exactly 19200 cycles, clr_done on the last one, all pixel outputs 000 throughout; wr_ready=1 the following cycle.
- Write (wr_x=5,wr_y=3,wr_rgb=101), then drive a full controller-timed frame -> RGB=101 exactly at x 20..23, y 12..15; 000 everywhere else.
- Write cell (0,4)=110 and cell (0,3)=011, run lines y=15 and y=16 -> x=0,1,2,3 give 011 on y=15 and 110 on y=16. This checks the row-boundary prefetch and the x==1 hold path.
- Write cell (159,119)=111 -> x=636..639, y=476..479 give 111. x=639 causes no out-of-range read; col clamped to 159.
- Write wr_x=160, wr_y=0, wr_rgb=111 -> accepted, wr_drop pulses once, and row 0 / cell (0,1) remain unchanged.
- In IDLE, assert clr_req with clr_rgb=010 and wr_valid in the same cycle -> the write completes, busy rises next cycle, then after 19200 cycles every visible pixel reads 010. Assert reset_n=0 at clear cycle 5000 -> the clear restarts with colour 000 and runs the full 19200 cycles.
